// File: rtl/mux2_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the downstream sink.
// The master side drives requests and y_ready; the slave side is the arbiter.
interface mux2_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_ready;
  logic             sel;
  logic             busy;

  modport master (
    output a_valid, a_data, b_valid, b_data, y_ready,
    input  a_ready, b_ready, y_valid, y_data, sel, busy
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, y_ready,
    output a_ready, b_ready, y_valid, y_data, sel, busy
  );
endinterface

// File: rtl/mux2_arbiter.sv
// Two-way round-robin burst arbiter with a registered grant; the output path is a
// combinational mux of the granted requester, so y_ready passes straight through.
module mux2_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic           clk,
  input logic           rst_n,
  mux2_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic             r_last_b;
  logic             w_last_b_nxt;
  logic             r_sel;
  logic             w_sel_nxt;

  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_to_idle;
  logic             w_cur_vld;
  logic             w_oth_vld;
  logic             w_beat;
  logic             w_release;
  logic             w_y_valid;
  logic [WIDTH-1:0] w_y_data;
  logic             w_a_ready;
  logic             w_b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_last_b <= 1'b1;
      r_sel    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_last_b <= w_last_b_nxt;
      r_sel    <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_last_b_nxt = r_last_b;
    w_sel_nxt    = r_sel;
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    w_to_idle    = 1'b0;
    w_cur_vld    = 1'b0;
    w_oth_vld    = 1'b0;
    w_beat       = 1'b0;
    w_release    = 1'b0;
    w_y_valid    = 1'b0;
    w_y_data     = '0;
    w_a_ready    = 1'b0;
    w_b_ready    = 1'b0;

    case (r_state)
      GNT_A: begin
        w_y_valid = bus.a_valid;
        w_y_data  = bus.a_data;
        w_a_ready = bus.y_ready;
        w_cur_vld = bus.a_valid;
        w_oth_vld = bus.b_valid;
      end
      GNT_B: begin
        w_y_valid = bus.b_valid;
        w_y_data  = bus.b_data;
        w_b_ready = bus.y_ready;
        w_cur_vld = bus.b_valid;
        w_oth_vld = bus.a_valid;
      end
      default: begin
        // Tie goes to whoever was not served last.
        if (bus.a_valid && (!bus.b_valid || r_last_b)) begin
          w_grant_a = 1'b1;
        end else if (bus.b_valid) begin
          w_grant_b = 1'b1;
        end
      end
    endcase

    if (r_state != IDLE) begin
      w_beat    = w_cur_vld && bus.y_ready;
      w_release = !w_cur_vld || (w_beat && (r_cnt == LAST_CNT));
      if (w_release) begin
        // Prefer handing over to the other side; otherwise regrant or go idle.
        if (w_oth_vld) begin
          w_grant_a = (r_state == GNT_B);
          w_grant_b = (r_state == GNT_A);
        end else if (w_cur_vld) begin
          w_grant_a = (r_state == GNT_A);
          w_grant_b = (r_state == GNT_B);
        end else begin
          w_to_idle = 1'b1;
        end
      end else if (w_beat) begin
        w_cnt_nxt = r_cnt + 4'd1;
      end
    end

    if (w_grant_a) begin
      w_state_nxt  = GNT_A;
      w_cnt_nxt    = 4'd0;
      w_last_b_nxt = 1'b0;
      w_sel_nxt    = 1'b0;
    end else if (w_grant_b) begin
      w_state_nxt  = GNT_B;
      w_cnt_nxt    = 4'd0;
      w_last_b_nxt = 1'b1;
      w_sel_nxt    = 1'b1;
    end else if (w_to_idle) begin
      w_state_nxt  = IDLE;
      w_cnt_nxt    = 4'd0;
    end
  end

  assign bus.y_valid = w_y_valid;
  assign bus.y_data  = w_y_data;
  assign bus.a_ready = w_a_ready;
  assign bus.b_ready = w_b_ready;
  assign bus.sel     = r_sel;
  assign bus.busy    = (r_state != IDLE);

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed and randomized bench for mux2_arbiter against a cycle-level reference
// model of the grant/burst rules.
module tb_mux2_arbiter;

  localparam int W    = 8;
  localparam int MAXB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  mux2_arbiter_if #(.WIDTH(W)) bus ();

  mux2_arbiter #(.WIDTH(W), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: owner -1 = nobody, 0 = A, 1 = B.
  int   m_owner;
  int   m_beats;
  int   m_last;
  logic m_sel;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_last  = 1;
    m_sel   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    32'(bus.busy),    32'd0);
    check({tag, "_y_valid"}, 32'(bus.y_valid), 32'd0);
    check({tag, "_a_ready"}, 32'(bus.a_ready), 32'd0);
    check({tag, "_b_ready"}, 32'(bus.b_ready), 32'd0);
    check({tag, "_sel"},     32'(bus.sel),     32'd0);
    check({tag, "_y_data"},  32'(bus.y_data),  32'd0);
  endtask

  task automatic do_reset();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.y_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Drive one cycle's inputs and compare every output against the model.
  task automatic drive_check(input logic av, input logic bv, input logic [W-1:0] ad,
                             input logic [W-1:0] bd, input logic yr);
    logic         e_v;
    logic [W-1:0] e_d;
    logic         e_ar;
    logic         e_br;
    bus.a_valid = av;
    bus.b_valid = bv;
    bus.a_data  = ad;
    bus.b_data  = bd;
    bus.y_ready = yr;
    #2;
    e_v  = 1'b0;
    e_d  = '0;
    e_ar = 1'b0;
    e_br = 1'b0;
    if (m_owner == 0) begin
      e_v  = av;
      e_d  = ad;
      e_ar = yr;
    end else if (m_owner == 1) begin
      e_v  = bv;
      e_d  = bd;
      e_br = yr;
    end
    check("y_valid", 32'(bus.y_valid), 32'(e_v));
    check("y_data",  32'(bus.y_data),  32'(e_d));
    check("a_ready", 32'(bus.a_ready), 32'(e_ar));
    check("b_ready", 32'(bus.b_ready), 32'(e_br));
    check("sel",     32'(bus.sel),     32'(m_sel));
    check("busy",    32'(bus.busy),    32'(m_owner >= 0));
  endtask

  // Apply the arbitration rules to this cycle's inputs, then cross the clock edge.
  task automatic advance();
    logic [1:0] v;
    logic       beat;
    int         nxt;
    bit         entry;
    v[0]  = bus.a_valid;
    v[1]  = bus.b_valid;
    nxt   = -1;
    entry = 1'b0;
    if (m_owner < 0) begin
      if (v[0] && v[1])  begin nxt = 1 - m_last; entry = 1'b1; end
      else if (v[0])     begin nxt = 0;          entry = 1'b1; end
      else if (v[1])     begin nxt = 1;          entry = 1'b1; end
    end else begin
      beat = v[m_owner] && bus.y_ready;
      if (beat) m_beats++;
      if (!v[m_owner] || (beat && m_beats == MAXB)) begin
        entry = 1'b1;
        if (v[1 - m_owner])  nxt = 1 - m_owner;
        else if (v[m_owner]) nxt = m_owner;
        else                 nxt = -1;
      end
    end
    if (entry) begin
      m_owner = nxt;
      m_beats = 0;
      if (nxt >= 0) begin
        m_last = nxt;
        m_sel  = nxt[0];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic av, input logic bv, input logic [W-1:0] ad,
                      input logic [W-1:0] bd, input logic yr);
    drive_check(av, bv, ad, bd, yr);
    advance();
  endtask

  initial begin
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_data  = '0;
    bus.b_data  = '0;
    bus.y_ready = 1'b0;
    model_reset();
    #1;
    do_reset();

    // Only B requests: granted the cycle after, data passes through.
    step(1'b0, 1'b1, 8'h11, 8'hC3, 1'b1);
    drive_check(1'b0, 1'b1, 8'h11, 8'hC3, 1'b1);
    check("b_only_sel",   32'(bus.sel),     32'd1);
    check("b_only_data",  32'(bus.y_data),  32'hC3);
    check("b_only_bredy", 32'(bus.b_ready), 32'd1);
    check("b_only_aredy", 32'(bus.a_ready), 32'd0);
    advance();

    // Both requesting: alternating 4-beat bursts, A first after reset.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      drive_check(1'b1, 1'b1, 8'(8'hA0 + c), 8'(8'hB0 + c), 1'b1);
      if (c >= 1) begin
        check("burst_sel",   32'(bus.sel),     32'(((c - 1) / MAXB) % 2));
        check("burst_valid", 32'(bus.y_valid), 32'd1);
      end
      advance();
    end

    // A drops after 2 beats while B waits: B takes over, its count starts fresh.
    do_reset();
    step(1'b1, 1'b0, 8'h01, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h02, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h03, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h04, 8'h50, 1'b1);
    for (int c = 0; c < 5; c++) begin
      drive_check(1'b1, 1'b1, 8'(8'h60 + c), 8'(8'h70 + c), 1'b1);
      check("handover_sel", 32'(bus.sel), (c < 4) ? 32'd1 : 32'd0);
      advance();
    end

    // Stall in GNT_A: grant and count held while y_ready is low.
    do_reset();
    step(1'b1, 1'b0, 8'h21, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h22, 8'h00, 1'b1);
    for (int c = 0; c < 5; c++) begin
      drive_check(1'b1, 1'b1, 8'h23, 8'h99, 1'b0);
      check("stall_sel",   32'(bus.sel),     32'd0);
      check("stall_valid", 32'(bus.y_valid), 32'd1);
      advance();
    end
    for (int c = 0; c < 6; c++) step(1'b1, 1'b1, 8'(8'h30 + c), 8'(8'h40 + c), 1'b1);

    // Lone A: continuous stream, regranted after every burst.
    do_reset();
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int c = 1; c < 14; c++) begin
      drive_check(1'b1, 1'b0, 8'(c), 8'h00, 1'b1);
      check("a_only_stream", 32'({bus.y_valid, bus.a_ready, bus.sel}), 32'b110);
      advance();
    end

    // Reset pulsed mid-burst in GNT_B, then a tie goes to A.
    do_reset();
    step(1'b0, 1'b1, 8'h00, 8'h77, 1'b1);
    step(1'b0, 1'b1, 8'h00, 8'h78, 1'b1);
    drive_check(1'b0, 1'b1, 8'h00, 8'h79, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b1, 8'hAA, 8'hBB, 1'b1);
    drive_check(1'b1, 1'b1, 8'hAB, 8'hBC, 1'b1);
    check("post_rst_sel",  32'(bus.sel),    32'd0);
    check("post_rst_data", 32'(bus.y_data), 32'hAB);
    advance();

    // Randomized traffic with sticky valids and random backpressure.
    begin
      logic av;
      logic bv;
      av = 1'b0;
      bv = 1'b0;
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 3) == 0) av = ~av;
        if ($urandom_range(0, 3) == 0) bv = ~bv;
        step(av, bv, 8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of every data port.
REQ-002 Parameter MAX_BURST, default 4: maximum beats per grant, legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 a_valid  input  1  requester A offers a beat.
REQ-006 a_data  input  WIDTH  requester A data.
REQ-007 a_ready  output  1  requester A beat accepted this cycle.
REQ-008 b_valid  input  1  requester B offers a beat.
REQ-009 b_data  input  WIDTH  requester B data.
REQ-010 b_ready  output  1  requester B beat accepted this cycle.
REQ-011 y_valid  output  1  muxed output beat valid.
REQ-012 y_data  output  WIDTH  muxed output data.
REQ-013 y_ready  input  1  downstream accepts the output beat.
REQ-014 sel  output  1  registered mux select: 0 selects A, 1 selects B.
REQ-015 busy  output  1  high while a grant is held.

Function
REQ-016 FSM states SHALL be IDLE, GNT_A and GNT_B; sel SHALL be 0 in GNT_A, 1 in GNT_B, and hold its last value in IDLE.
REQ-017 A beat SHALL be any cycle with y_valid and y_ready both high.
REQ-018 In GNT_A, y_valid SHALL equal a_valid, y_data SHALL equal a_data, a_ready SHALL equal y_ready, and b_ready SHALL be 0; GNT_B SHALL mirror this with A and B swapped.
REQ-019 In IDLE, y_valid, a_ready and b_ready SHALL be 0, y_data SHALL be all zeros, and busy SHALL be 0.
REQ-020 Arbitration SHALL be registered: a valid seen in cycle N SHALL produce a grant in cycle N+1, so the first beat is no earlier than cycle N+1.
REQ-021 From IDLE: only a_valid high -> GNT_A; only b_valid high -> GNT_B; both high -> grant the requester that was not served last (round-robin via a last-served flag); neither high -> stay in IDLE.
REQ-022 A beat counter SHALL clear on every grant entry and increment by 1 on each beat.
REQ-023 A grant SHALL release on the beat that brings the count to MAX_BURST, or in any granted cycle where the granted requester's valid is low (no beat occurs in that cycle).
REQ-024 On release, the other requester's valid high -> switch directly to its grant with no IDLE cycle.
REQ-025 On release with the other requester's valid low and the current requester's valid high -> regrant the current requester with the counter cleared.
REQ-026 On release with neither valid high -> IDLE.
REQ-027 The last-served flag SHALL update on every grant entry.
REQ-028 Stalls (y_ready low while valid is high) SHALL hold the grant and the counter indefinitely without releasing.
REQ-029 The ungranted requester's valid and data SHALL never affect y_valid or y_data.

Reset
REQ-030 While rst_n is low, the FSM SHALL be in IDLE, sel 0, counter 0, last-served flag set to B (so A wins the first tie), busy 0, y_valid 0, a_ready 0, b_ready 0.
REQ-031 Reset asserted mid-burst SHALL abort the grant immediately with no further beats; after release, arbitration SHALL restart per REQ-021.

Verification
REQ-032 Both valids held high, y_ready=1, MAX_BURST=4 -> 4 beats of A (sel=0), then 4 beats of B (sel=1), alternating, with no idle cycle between bursts.
REQ-033 Only b_valid high with b_data=8'hC3 -> cycle 1 GNT_B, sel=1, y_data=8'hC3, b_ready=1, a_ready=0.
REQ-034 In GNT_A after 2 beats, a_valid drops with b_valid high -> GNT_B the next cycle and B's counter restarts at 0.
REQ-035 In GNT_A, y_ready=0 for 5 cycles -> a_ready=0, y_valid=1, grant held, count unchanged, sel stays 0.
REQ-036 rst_n pulsed low mid-burst in GNT_B -> outputs take their reset values (REQ-030) asynchronously; afterwards both valids high -> A granted first.
REQ-037 Only a_valid held high, MAX_BURST=4 -> A regranted after every 4th beat, with a continuous beat stream and sel=0 throughout.
